// File: rtl/exec_unit.sv
// Execution unit: single-cycle ALU/branch/LUI/AUIPC/JAL class plus an iterative
// shift-add multiplier and an optional restoring divider (enabled by EXEC_UNIT_DIV_EN).
module exec_unit #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_control,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal_op,
  input  logic            flush
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_XOR  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_SLT  = 5'd8,  OP_SLTU = 5'd9,  OP_BEQ  = 5'd10, OP_BNE  = 5'd11;
  localparam logic [4:0] OP_BLT  = 5'd12, OP_BGE  = 5'd13, OP_BLTU = 5'd14, OP_BGEU = 5'd15;
  localparam logic [4:0] OP_LUI  = 5'd16, OP_AUIPC = 5'd17, OP_JAL = 5'd18, OP_JALR = 5'd19;
  localparam logic [4:0] OP_MULH = 5'd21, OP_MULHSU = 5'd22;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;
  logic   accept, is_mul, is_div, multi, last;

  logic [XLEN-1:0]   alu_res;
  logic              alu_br, alu_ill;
  logic              sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;

  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] work_q, work_next, mul_next, mul_fix;
  logic [XLEN:0]     mul_sum;
  logic [1:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   fin_res;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (alu_control[4:2] == 3'b101);
`ifdef EXEC_UNIT_DIV_EN
  assign is_div    = (alu_control[4:2] == 3'b110);
`else
  assign is_div    = 1'b0;
`endif
  assign multi     = is_mul || is_div;
  assign last      = (cnt_q == CNT_W'(XLEN - 1));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (alu_control)
      OP_ADD:   alu_res = op1 + op2;
      OP_SUB:   alu_res = op1 - op2;
      OP_XOR:   alu_res = op1 ^ op2;
      OP_OR:    alu_res = op1 | op2;
      OP_AND:   alu_res = op1 & op2;
      OP_SLL:   alu_res = op1 << op2[SHAMT_W-1:0];
      OP_SRL:   alu_res = op1 >> op2[SHAMT_W-1:0];
      OP_SRA:   alu_res = $signed(op1) >>> op2[SHAMT_W-1:0];
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      OP_BEQ:   alu_br  = (op1 == op2);
      OP_BNE:   alu_br  = (op1 != op2);
      OP_BLT:   alu_br  = ($signed(op1) <  $signed(op2));
      OP_BGE:   alu_br  = ($signed(op1) >= $signed(op2));
      OP_BLTU:  alu_br  = (op1 <  op2);
      OP_BGEU:  alu_br  = (op1 >= op2);
      OP_LUI:   alu_res = op2 << 12;
      OP_AUIPC: alu_res = pc + (op2 << 12);
      OP_JAL, OP_JALR: alu_res = pc + XLEN'(4);
      default:  alu_ill = !multi;
    endcase
  end

  // Signedness of each operand; iterative units work on magnitudes and fix the sign at the end.
  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    if (alu_control == OP_MULH) begin
      sgn1 = op1[XLEN-1];
      sgn2 = op2[XLEN-1];
    end else if (alu_control == OP_MULHSU) begin
      sgn1 = op1[XLEN-1];
    end
`ifdef EXEC_UNIT_DIV_EN
    if (is_div && !alu_control[0]) begin
      sgn1 = op1[XLEN-1];
      sgn2 = op2[XLEN-1];
    end
`endif
    mag1 = sgn1 ? -op1 : op1;
    mag2 = sgn2 ? -op2 : op2;
  end

  // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
  assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, work_q[XLEN-1:1]};
  assign mul_fix  = neg_q ? -mul_next : mul_next;

`ifdef EXEC_UNIT_DIV_EN
  logic              div_q, neg_rem_q, dz_q;
  logic [XLEN-1:0]   op1_q, quot, rem;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [2*XLEN-1:0] div_next;

  // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign rem_sh   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, a_q};
  assign div_next = rem_diff[XLEN] ? {rem_sh[XLEN-1:0],   work_q[XLEN-2:0], 1'b0}
                                   : {rem_diff[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
  assign work_next = div_q ? div_next : mul_next;
  assign quot      = div_next[XLEN-1:0];
  assign rem       = div_next[2*XLEN-1:XLEN];
`else
  assign work_next = mul_next;
`endif

  always_comb begin
    fin_res = (op_q == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
`ifdef EXEC_UNIT_DIV_EN
    if (div_q) begin
      if (op_q[1]) fin_res = dz_q ? op1_q : (neg_rem_q ? -rem : rem);
      else         fin_res = dz_q ? '1    : (neg_q ? -quot : quot);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = multi ? BUSY : DONE;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      cnt_q        <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      if (!multi) begin
        result       <= alu_res;
        branch_taken <= alu_br;
        illegal_op   <= alu_ill;
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (last) begin
        result       <= fin_res;
        branch_taken <= 1'b0;
        illegal_op   <= 1'b0;
        cnt_q        <= '0;
      end
    end
  end

  // NOTE: operand/work registers carry no reset; they are always loaded on acceptance before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= alu_control[1:0];
      neg_q  <= sgn1 ^ sgn2;
      a_q    <= is_div ? mag2 : mag1;
      work_q <= {XLEN'(0), is_div ? mag1 : mag2};
`ifdef EXEC_UNIT_DIV_EN
      div_q     <= is_div;
      neg_rem_q <= sgn1;
      dz_q      <= (op2 == '0);
      op1_q     <= op1;
`endif
    end else if (state_q == BUSY) begin
      work_q <= work_next;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit (XLEN=32): directed corner cases plus random
// operations checked against an arithmetic reference model.
module tb_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, out_ready, flush;
  logic [4:0]      alu_control;
  logic [XLEN-1:0] op1, op2, pc;
  logic            in_ready, out_valid, branch_taken, illegal_op;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op1(op1), .op2(op2), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .illegal_op(illegal_op), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: architectural result of one operation and its latency in cycles.
  function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] p, output logic [31:0] r, output logic br,
                                output logic ill, output int lat);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    sa = a; sb = b;
    r = 32'd0; br = 1'b0; ill = 1'b0; lat = 1;
    case (c)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a ^ b;
      5'd3:  r = a | b;
      5'd4:  r = a & b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = sa >>> b[4:0];
      5'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: br = (a == b);
      5'd11: br = (a != b);
      5'd12: br = (sa < sb);
      5'd13: br = (sa >= sb);
      5'd14: br = (a < b);
      5'd15: br = (a >= b);
      5'd16: r = b << 12;
      5'd17: r = p + (b << 12);
      5'd18, 5'd19: r = p + 32'd4;
      5'd20: begin r = a * b; lat = 33; end
      5'd21: begin ps = longint'(sa) * longint'(sb); r = ps[63:32]; lat = 33; end
      5'd22: begin ps = longint'(sa) * longint'({32'd0, b}); r = ps[63:32]; lat = 33; end
      5'd23: begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; lat = 33; end
`ifdef EXEC_UNIT_DIV_EN
      5'd24: begin
        lat = 33;
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = sa / sb;
      end
      5'd25: begin lat = 33; r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
      5'd26: begin
        lat = 33;
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = sa % sb;
      end
      5'd27: begin lat = 33; r = (b == 0) ? a : a % b; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] p, input int hold);
    logic [31:0] er;
    logic        eb, ei;
    int          el, lat;
    model(c, a, b, p, er, eb, ei, el);
    @(negedge clk);
    check($sformatf("%s.in_ready", tag), in_ready, 1);
    in_valid = 1'b1; alu_control = c; op1 = a; op2 = b; pc = p;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s.latency c=%0d", tag, c), lat, el);
    check($sformatf("%s.result c=%0d a=%h b=%h", tag, c, a, b), result, er);
    check($sformatf("%s.branch c=%0d", tag, c), branch_taken, eb);
    check($sformatf("%s.illegal c=%0d", tag, c), illegal_op, ei);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s.hold_valid", tag), out_valid, 1);
      check($sformatf("%s.hold_ready", tag), in_ready, 0);
      check($sformatf("%s.hold_result", tag), result, er);
      check($sformatf("%s.hold_branch", tag), branch_taken, eb);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s.release_valid", tag), out_valid, 0);
    check($sformatf("%s.release_ready", tag), in_ready, 1);
  endtask

  task automatic abort_mul(input bit use_rst);
    string tag;
    bit    seen;
    tag = use_rst ? "rst_abort" : "flush_abort";
    @(negedge clk);
    in_valid = 1'b1; alu_control = 5'd20; op1 = 32'd12345; op2 = 32'd678; pc = '0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    check({tag, ".valid"}, out_valid, 0);
    check({tag, ".ready"}, in_ready, 1);
    if (use_rst) check({tag, ".result"}, result, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check({tag, ".no_pulse"}, seen, 0);
  endtask

  initial begin
    bit          seen;
    logic [4:0]  c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    alu_control = '0; op1 = '0; op2 = '0; pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.valid", out_valid, 0);
    check("reset.ready", in_ready, 1);
    check("reset.result", result, 0);
    check("reset.branch", branch_taken, 0);
    check("reset.illegal", illegal_op, 0);

    run_op("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
    run_op("mulh_min", 5'd21, 32'h8000_0000, 32'h8000_0000, 32'd0, 0);
    run_op("div_ovf", 5'd24, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("divu_zero", 5'd25, 32'd7, 32'd0, 32'd0, 0);
    run_op("rem_neg", 5'd26, 32'hFFFF_FFF9, 32'd2, 32'd0, 0);
    run_op("rem_zero", 5'd26, 32'hFFFF_FFF9, 32'd0, 32'd0, 1);
    run_op("blt_hold", 5'd12, 32'hFFFF_FFFF, 32'd0, 32'd0, 5);
    run_op("illegal", 5'd31, 32'd5, 32'd6, 32'd0, 1);
    run_op("auipc", 5'd17, 32'd0, 32'h000A_BCDE, 32'h1000_0000, 0);
    run_op("jal", 5'd18, 32'd0, 32'd0, 32'hFFFF_FFFE, 0);
    run_op("sra", 5'd7, 32'h8000_0000, 32'h0000_0024, 32'd0, 0);

    abort_mul(1'b0);
    abort_mul(1'b1);

    // Flush in the same cycle as a request: the request must be dropped.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; alu_control = 5'd0; op1 = 32'd1; op2 = 32'd2;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    seen = out_valid;
    repeat (3) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush_accept.no_valid", seen, 0);
    check("flush_accept.ready", in_ready, 1);

    for (int i = 0; i < 200; i++) begin
      c = 5'($urandom_range(0, 31));
      run_op("rand", c, rand_val(), rand_val(), $urandom, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter SHAMT_W, default $clog2(XLEN), shift-amount width taken from op2 LSBs.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts request this cycle.
REQ-007 alu_control  input  5  operation code.
REQ-008 op1, op2  input  XLEN each  operands.
REQ-009 pc  input  XLEN  instruction address for AUIPC/JAL/JALR.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  XLEN  registered result.
REQ-013 branch_taken  output  1  registered branch decision.
REQ-014 illegal_op  output  1  registered; code not supported.
REQ-015 flush  input  1  abort in-flight operation.

Function
REQ-016 SHALL accept a request on a rising edge where in_valid && in_ready, capturing alu_control, op1, op2, pc.
REQ-017 SHALL use states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-018 Codes 00000-10011: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU, LUI (op2<<12), AUIPC (pc+(op2<<12)), JAL/JALR (pc+4); single-cycle class, IDLE->DONE, out_valid on the edge after acceptance.
REQ-019 Shifts SHALL use op2[SHAMT_W-1:0]; all arithmetic modulo 2^XLEN.
REQ-020 Branch codes SHALL drive result = 0 and set branch_taken; all other codes drive branch_taken = 0.
REQ-021 Codes 10100 MUL, 10101 MULH, 10110 MULHSU, 10111 MULHU SHALL use an iterative radix-2 shift-add multiplier, IDLE->BUSY, one bit per cycle, out_valid exactly XLEN+1 cycles after acceptance.
REQ-022 Codes 11000 DIV, 11001 DIVU, 11010 REM, 11011 REMU SHALL use a restoring divider (signed via magnitude + sign fix-up), same XLEN+1 latency.
REQ-023 Divide by zero: DIV/DIVU quotient = all ones, REM/REMU remainder = op1; latency unchanged.
REQ-024 DIV overflow (op1 = most-negative, op2 = -1): quotient = op1, remainder = 0.
REQ-025 Codes 11100-11111 SHALL be illegal: result = 0, illegal_op = 1, single-cycle class.
REQ-026 In DONE, result/branch_taken/illegal_op SHALL hold stable while out_valid && !out_ready; DONE->IDLE on out_ready.
REQ-027 flush SHALL force state IDLE and out_valid = 0 next edge from any state; flush wins over a simultaneous acceptance (request dropped).
REQ-028 Cycle counter in BUSY SHALL be $clog2(XLEN)+1 bits and not wrap before completion.

Reset
REQ-029 On rst: state IDLE, out_valid = 0, result = 0, branch_taken = 0, illegal_op = 0, counter = 0, in_ready = 1 the following cycle.
REQ-030 rst mid-operation SHALL discard the operation with no out_valid pulse; rst has priority over flush and in_valid.

Configuration
REQ-031 Macro EXEC_UNIT_DIV_EN: when defined, divider present per REQ-022..024.
REQ-032 Without EXEC_UNIT_DIV_EN, codes 11000-11011 SHALL behave as illegal (REQ-025) and no divider logic SHALL be synthesised; multiplier unaffected.

Verification
REQ-033 ADD op1=0xFFFFFFFF op2=1 (XLEN=32) -> result 0x00000000, out_valid 1 cycle after accept.
REQ-034 MULH op1=0x80000000 op2=0x80000000 -> result 0x40000000 exactly 33 cycles after accept.
REQ-035 DIV op1=0x80000000 op2=0xFFFFFFFF -> result 0x80000000; DIVU op1=7 op2=0 -> 0xFFFFFFFF; REM op1=-7 op2=2 -> 0xFFFFFFFF.
REQ-036 BLT op1=-1 op2=0 with out_ready held low 5 cycles -> branch_taken 1, result 0, outputs stable, in_ready 0 until out_ready.
REQ-037 MUL accepted, flush asserted at cycle 10 -> no out_valid, in_ready 1 next cycle; same with rst.
REQ-038 Code 11111 -> illegal_op 1, result 0; with EXEC_UNIT_DIV_EN undefined, DIVU -> illegal_op 1.
